// File: rtl/cpu_wb_mul_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_wb_mul_arbiter
//
// Round-robin arbiter that shares one combinational carry-look-ahead array
// multiplier (cpu_wb_cla_multiplier, also in this file) between NUM_REQ
// writeback-side requesters. A granted request has its operands registered.
// The operands are then held for MUL_CYCLES cycles, which the multiplier
// treats as a multicycle path. The 2*DATA_WID product is registered next and
// returned to the owner over a one-hot valid/ready handshake.
//
// Optional feature macro: CPU_WB_MUL_SIGNED_EN
//   defined   : req_signed selects two's-complement multiplication (operands
//               reduced to magnitudes, sign re-applied at product capture)
//   undefined : req_signed is ignored, all operations are unsigned
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   req_valid    in   [NUM_REQ]            per-requester request valid
//   req_ready    out  [NUM_REQ]            per-requester accept (one-hot or 0)
//   req_a        in   [NUM_REQ*DATA_WID]   multiplicands, k at [k*DATA_WID +: DATA_WID]
//   req_b        in   [NUM_REQ*DATA_WID]   multipliers, same packing
//   req_signed   in   [NUM_REQ]            signed-operation flags
//   rsp_valid    out  [NUM_REQ]            registered one-hot response valid
//   rsp_ready    in   [NUM_REQ]            per-requester response accept
//   rsp_product  out  [2*DATA_WID]         registered product
//   busy         out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------

// Combinational DATA_WID x DATA_WID array multiplier. Each row adds one gated,
// shifted partial product into the running sum through a parallel-prefix
// (carry-look-ahead) adder.
module cpu_wb_cla_multiplier #(
    parameter int DATA_WID = 32
) (
    input  logic [DATA_WID-1:0]   a,
    input  logic [DATA_WID-1:0]   b,
    output logic [2*DATA_WID-1:0] product
);
    localparam int PW = 2 * DATA_WID;

    // Kogge-Stone style look-ahead adder, carry-in fixed at zero.
    function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y);
        logic [PW-1:0] p;
        logic [PW-1:0] gg;
        logic [PW-1:0] pp;
        p  = x ^ y;
        gg = x & y;
        pp = p;
        for (int d = 1; d < PW; d = d * 2) begin
            // Descending index so bit i-d still holds the previous level.
            for (int i = PW - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        // gg[i] is the carry out of bits [i:0], i.e. the carry into bit i+1.
        return p ^ (gg << 1);
    endfunction

    // Partial-product array accumulation.
    always_comb begin
        logic [PW-1:0] acc;
        logic [PW-1:0] row;
        acc = {PW{1'b0}};
        row = {PW{1'b0}};
        for (int i = 0; i < DATA_WID; i++) begin
            row = {{DATA_WID{1'b0}}, (a & {DATA_WID{b[i]}})} << i;
            acc = cla_add(acc, row);
        end
        product = acc;
    end
endmodule

module cpu_wb_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WID   = 32,
    parameter int MUL_CYCLES = 2,
    parameter int ID_WID     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_WID-1:0] req_a,
    input  logic [NUM_REQ*DATA_WID-1:0] req_b,
    input  logic [NUM_REQ-1:0]          req_signed,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [2*DATA_WID-1:0]       rsp_product,
    output logic                        busy
);
    localparam int PW      = 2 * DATA_WID;
    localparam int CNT_WID = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [CNT_WID-1:0] CNT_LOAD = CNT_WID'(MUL_CYCLES - 1);
    localparam logic [CNT_WID-1:0] CNT_ONE  = {{(CNT_WID-1){1'b0}}, 1'b1};
    localparam logic [CNT_WID-1:0] CNT_ZERO = {CNT_WID{1'b0}};
    localparam logic [ID_WID-1:0]  ID_ONE   = {{(ID_WID-1){1'b0}}, 1'b1};
    localparam logic [ID_WID-1:0]  ID_ZERO  = {ID_WID{1'b0}};
    localparam logic [ID_WID-1:0]  ID_LAST  = ID_WID'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ZERO = {NUM_REQ{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [ID_WID-1:0]   ptr_r;
    logic [ID_WID-1:0]   owner_r;
    logic [CNT_WID-1:0]  cnt_r;
    logic [DATA_WID-1:0] a_r;
    logic [DATA_WID-1:0] b_r;
    logic [PW-1:0]       product_r;
    logic [NUM_REQ-1:0]  rsp_valid_r;

    logic [ID_WID-1:0]   grant_s;
    logic                grant_found_s;
    logic                accept_s;
    logic                capture_s;
    logic                rsp_done_s;
    logic [DATA_WID-1:0] sel_a_s;
    logic [DATA_WID-1:0] sel_b_s;
    logic                sel_signed_s;
    logic [DATA_WID-1:0] op_a_s;
    logic [DATA_WID-1:0] op_b_s;
    logic [PW-1:0]       mul_product_s;
    logic [PW-1:0]       result_s;

    // Round-robin search from the pointer upward, wrapping past NUM_REQ-1.
    always_comb begin
        int                idx_int;
        logic [ID_WID-1:0] idx;
        grant_s       = ID_ZERO;
        grant_found_s = 1'b0;
        idx_int       = 0;
        idx           = ID_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_int       = int'(ptr_r) + i;
            idx_int       = (idx_int >= NUM_REQ) ? (idx_int - NUM_REQ) : idx_int;
            idx           = ID_WID'(idx_int);
            grant_s       = (!grant_found_s && req_valid[idx]) ? idx : grant_s;
            grant_found_s = grant_found_s | req_valid[idx];
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s      = {DATA_WID{1'b0}};
        sel_b_s      = {DATA_WID{1'b0}};
        sel_signed_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_a_s      = (grant_s == ID_WID'(k)) ? req_a[k*DATA_WID +: DATA_WID] : sel_a_s;
            sel_b_s      = (grant_s == ID_WID'(k)) ? req_b[k*DATA_WID +: DATA_WID] : sel_b_s;
            sel_signed_s = (grant_s == ID_WID'(k)) ? req_signed[k] : sel_signed_s;
        end
    end

    assign accept_s   = (state_r == ST_IDLE) && grant_found_s;
    assign capture_s  = (state_r == ST_CALC) && (cnt_r == CNT_ZERO);
    assign rsp_done_s = (state_r == ST_RESP) && (rsp_valid_r != REQ_ZERO) && rsp_ready[owner_r];

`ifdef CPU_WB_MUL_SIGNED_EN
    localparam logic [DATA_WID-1:0] D_ONE = {{(DATA_WID-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       P_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic neg_r;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is its correct unsigned magnitude.
    function automatic logic [DATA_WID-1:0] magnitude(input logic [DATA_WID-1:0] x,
                                                      input logic              en);
        return (en && x[DATA_WID-1]) ? (~x + D_ONE) : x;
    endfunction

    // Signed requests feed magnitudes to the unsigned multiplier.
    always_comb begin
        op_a_s = magnitude(sel_a_s, sel_signed_s);
        op_b_s = magnitude(sel_b_s, sel_signed_s);
    end

    // Result sign, latched with the operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (accept_s) begin
            neg_r <= sel_signed_s & (sel_a_s[DATA_WID-1] ^ sel_b_s[DATA_WID-1]);
        end else begin
            neg_r <= neg_r;
        end
    end

    // Re-apply the sign over the full product width.
    always_comb begin
        if (neg_r) begin
            result_s = ~mul_product_s + P_ONE;
        end else begin
            result_s = mul_product_s;
        end
    end
`else
    logic unused_signed_s;

    assign unused_signed_s = ^{req_signed, sel_signed_s};

    // Unsigned only: operands and product pass straight through.
    always_comb begin
        op_a_s   = sel_a_s;
        op_b_s   = sel_b_s;
        result_s = mul_product_s;
    end
`endif

    cpu_wb_cla_multiplier #(
        .DATA_WID (DATA_WID)
    ) u_mul (
        .a       (a_r),
        .b       (b_r),
        .product (mul_product_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: grant strobe only from IDLE and never while reset is held.
    always_comb begin
        if ((state_r == ST_IDLE) && grant_found_s && rst_n) begin
            req_ready = REQ_ONE << grant_s;
        end else begin
            req_ready = REQ_ZERO;
        end
        busy = (state_r != ST_IDLE);
    end

    // Operand, owner, hold-counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {DATA_WID{1'b0}};
            b_r     <= {DATA_WID{1'b0}};
            owner_r <= ID_ZERO;
            cnt_r   <= CNT_ZERO;
            ptr_r   <= ID_ZERO;
        end else if (accept_s) begin
            a_r     <= op_a_s;
            b_r     <= op_b_s;
            owner_r <= grant_s;
            cnt_r   <= CNT_LOAD;
            // The requester just served drops to lowest priority.
            ptr_r   <= (grant_s == ID_LAST) ? ID_ZERO : (grant_s + ID_ONE);
        end else if ((state_r == ST_CALC) && (cnt_r != CNT_ZERO)) begin
            cnt_r   <= cnt_r - CNT_ONE;
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Product capture and the registered one-hot response valid. Valid rises
    // on the first RESP edge, one edge after capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product_r   <= {PW{1'b0}};
            rsp_valid_r <= REQ_ZERO;
        end else begin
            if (capture_s) begin
                product_r <= result_s;
            end else begin
                product_r <= product_r;
            end
            if ((state_r == ST_RESP) && (rsp_valid_r == REQ_ZERO)) begin
                rsp_valid_r <= REQ_ONE << owner_r;
            end else if (rsp_done_s) begin
                rsp_valid_r <= REQ_ZERO;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_product = product_r;
endmodule
